// File: rtl/opl3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : opl3_pkg
//  Description : Shared widths, frame size and mixer state encoding for the
//                OPL3 channel mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
package opl3_pkg;

    localparam int OP_OUT_WIDTH  = 13;  // signed operator output
    localparam int OPS_PER_FRAME = 36;  // operator slots per sample frame
    localparam int MIX_ACC_WIDTH = 20;  // holds 36 * 2^(OP_OUT_WIDTH-1) without overflow
    localparam int SAMPLE_WIDTH  = 16;  // signed output sample
    localparam int OP_CNT_WIDTH  = 6;   // enough to count up to OPS_PER_FRAME

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CLAMP = 2'd2
    } mixer_state_t;

endpackage
`default_nettype wire

// File: rtl/mixer_saturate.sv
`default_nettype none
// ============================================================================
//  Module      : mixer_saturate
//  Description : Combinational clamp of a wide signed accumulator into a
//                narrower signed sample, flagging when clamping occurred.
//  Revision    : 1.0 - initial release
// ============================================================================
module mixer_saturate #(
    parameter int ACC_WIDTH = 20,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    output logic signed [OUT_WIDTH-1:0] o_sample,
    output logic                        o_clipped
);

    localparam logic signed [ACC_WIDTH-1:0] c_sat_max = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] c_sat_min = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    // Pass the low bits through when in range, otherwise pin to the nearest rail.
    always_comb begin
        o_sample  = i_acc[OUT_WIDTH-1:0];
        o_clipped = 1'b0;
        if (i_acc > c_sat_max) begin
            o_sample  = c_sat_max[OUT_WIDTH-1:0];
            o_clipped = 1'b1;
        end else if (i_acc < c_sat_min) begin
            o_sample  = c_sat_min[OUT_WIDTH-1:0];
            o_clipped = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/channel_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : channel_mixer
//  Description : Sums carrier operator outputs into left/right accumulators
//                over one sample frame, saturates and emits one stereo sample
//                per frame. Optional macro OPL3_MIX_CLIP_COUNT_EN adds a
//                saturating clip event counter port (clip_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_mixer
    import opl3_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_clk_en,
    input  logic                           op_valid,
    input  logic signed [OP_OUT_WIDTH-1:0] op_out,
    input  logic                           op_is_carrier,
    input  logic                           op_left_en,
    input  logic                           op_right_en,
    output logic signed [SAMPLE_WIDTH-1:0] sample_l,
    output logic signed [SAMPLE_WIDTH-1:0] sample_r,
    output logic                           sample_valid,
    output logic                           frame_error
`ifdef OPL3_MIX_CLIP_COUNT_EN
    ,
    output logic [15:0]                    clip_count
`endif
);

    mixer_state_t                    r_state, w_state_next;
    logic signed [MIX_ACC_WIDTH-1:0] r_acc_l, r_acc_r;
    logic signed [MIX_ACC_WIDTH-1:0] w_acc_l_next, w_acc_r_next, w_op_ext;
    logic [OP_CNT_WIDTH-1:0]         r_op_cnt, w_op_cnt_next;
    logic                            w_op_take;
    logic signed [SAMPLE_WIDTH-1:0]  r_sample_l, r_sample_r;
    logic signed [SAMPLE_WIDTH-1:0]  w_sat_l, w_sat_r;
    logic                            w_clip_l, w_clip_r;
    logic                            r_sample_valid, r_frame_error;

    assign w_op_ext = {{(MIX_ACC_WIDTH - OP_OUT_WIDTH){op_out[OP_OUT_WIDTH-1]}}, op_out};

    // Frame accumulation and state sequencing; a frame strobe restarts from
    // cleared accumulators and an op in the same cycle is the frame's first.
    always_comb begin
        w_op_take     = op_valid && (sample_clk_en || (r_state == ACCUM));
        w_acc_l_next  = sample_clk_en ? '0 : r_acc_l;
        w_acc_r_next  = sample_clk_en ? '0 : r_acc_r;
        w_op_cnt_next = sample_clk_en ? '0 : r_op_cnt;
        w_state_next  = r_state;

        if (w_op_take) begin
            w_op_cnt_next = w_op_cnt_next + OP_CNT_WIDTH'(1);
            if (op_is_carrier && op_left_en)
                w_acc_l_next = w_acc_l_next + w_op_ext;
            if (op_is_carrier && op_right_en)
                w_acc_r_next = w_acc_r_next + w_op_ext;
        end

        if (sample_clk_en) begin
            w_state_next = ACCUM;
        end else begin
            unique case (r_state)
                ACCUM:   if (w_op_take && (w_op_cnt_next == OP_CNT_WIDTH'(OPS_PER_FRAME)))
                             w_state_next = CLAMP;
                CLAMP:   w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State, accumulator and op counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_op_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_acc_l  <= w_acc_l_next;
            r_acc_r  <= w_acc_r_next;
            r_op_cnt <= w_op_cnt_next;
        end
    end

    mixer_saturate #(
        .ACC_WIDTH (MIX_ACC_WIDTH),
        .OUT_WIDTH (SAMPLE_WIDTH)
    ) u_sat_l (
        .i_acc     (r_acc_l),
        .o_sample  (w_sat_l),
        .o_clipped (w_clip_l)
    );

    mixer_saturate #(
        .ACC_WIDTH (MIX_ACC_WIDTH),
        .OUT_WIDTH (SAMPLE_WIDTH)
    ) u_sat_r (
        .i_acc     (r_acc_r),
        .o_sample  (w_sat_r),
        .o_clipped (w_clip_r)
    );

    // Register the clamped sample in CLAMP and flag restarts that cut a frame short.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample_l     <= '0;
            r_sample_r     <= '0;
            r_sample_valid <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_sample_valid <= (r_state == CLAMP);
            if (r_state == CLAMP) begin
                r_sample_l <= w_sat_l;
                r_sample_r <= w_sat_r;
            end
            if (sample_clk_en && (r_state == ACCUM))
                r_frame_error <= 1'b1;
        end
    end

`ifdef OPL3_MIX_CLIP_COUNT_EN
    logic [15:0] r_clip_count;

    // One count per clipped frame regardless of how many channels clipped.
    always_ff @(posedge clk) begin
        if (reset)
            r_clip_count <= '0;
        else if ((r_state == CLAMP) && (w_clip_l || w_clip_r) && (r_clip_count != 16'hFFFF))
            r_clip_count <= r_clip_count + 16'd1;
    end

    assign clip_count = r_clip_count;
`else
    // Clip flags have no consumer when the counter is not built.
    logic w_clip_unused;
    assign w_clip_unused = w_clip_l | w_clip_r;
`endif

    assign sample_l     = r_sample_l;
    assign sample_r     = r_sample_r;
    assign sample_valid = r_sample_valid;
    assign frame_error  = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_channel_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel_mixer
//  Description : Self-checking bench for channel_mixer: directed frames plus
//                randomized frames against a frame-level sum/clamp model with
//                a scoreboard queue and an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_mixer;
    import opl3_pkg::*;

    logic                           clk = 1'b0;
    logic                           reset = 1'b1;
    logic                           sample_clk_en = 1'b0;
    logic                           op_valid = 1'b0;
    logic signed [OP_OUT_WIDTH-1:0] op_out = '0;
    logic                           op_is_carrier = 1'b0;
    logic                           op_left_en = 1'b0;
    logic                           op_right_en = 1'b0;
    logic signed [SAMPLE_WIDTH-1:0] sample_l, sample_r;
    logic                           sample_valid, frame_error;
`ifdef OPL3_MIX_CLIP_COUNT_EN
    logic [15:0]                    clip_count;
`endif

    channel_mixer dut (
        .clk           (clk),
        .reset         (reset),
        .sample_clk_en (sample_clk_en),
        .op_valid      (op_valid),
        .op_out        (op_out),
        .op_is_carrier (op_is_carrier),
        .op_left_en    (op_left_en),
        .op_right_en   (op_right_en),
        .sample_l      (sample_l),
        .sample_r      (sample_r),
        .sample_valid  (sample_valid),
        .frame_error   (frame_error)
`ifdef OPL3_MIX_CLIP_COUNT_EN
        ,
        .clip_count    (clip_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int l;
        int r;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Frame-level reference state
    bit   m_in_frame = 0;
    bit   m_ferr     = 0;
    int   m_cnt      = 0;
    int   m_sum_l    = 0;
    int   m_sum_r    = 0;
    int   m_last_l   = 0;
    int   m_last_r   = 0;
    int   m_clips    = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int sat(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    // Drive one cycle of inputs and advance the frame-level model.
    task automatic drive(input bit sce, input bit v, input int val,
                         input bit car, input bit le, input bit re);
        exp_t e;
        @(negedge clk);
        sample_clk_en = sce;
        op_valid      = v;
        op_out        = OP_OUT_WIDTH'(val);
        op_is_carrier = car;
        op_left_en    = le;
        op_right_en   = re;
        if (sce) begin
            if (m_in_frame) m_ferr = 1;
            m_in_frame = 1;
            m_cnt   = 0;
            m_sum_l = 0;
            m_sum_r = 0;
        end
        if (v && m_in_frame) begin
            m_cnt++;
            if (car && le) m_sum_l += val;
            if (car && re) m_sum_r += val;
            if (m_cnt == OPS_PER_FRAME) begin
                e.l   = sat(m_sum_l);
                e.r   = sat(m_sum_r);
                e.cyc = cyc + 2;
                q.push_back(e);
                if (e.l != m_sum_l || e.r != m_sum_r) m_clips++;
                m_last_l   = e.l;
                m_last_r   = e.r;
                m_in_frame = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk("pending_samples", q.size(), 0);
        chk("hold_l", int'(sample_l), m_last_l);
        chk("hold_r", int'(sample_r), m_last_r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        sample_clk_en = 1'b0;
        op_valid      = 1'b0;
        q.delete();
        m_in_frame = 0;
        m_ferr     = 0;
        m_cnt      = 0;
        m_last_l   = 0;
        m_last_r   = 0;
        m_clips    = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_sample_l", int'(sample_l), 0);
        chk("reset_sample_r", int'(sample_r), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_frame_error", int'(frame_error), 0);
`ifdef OPL3_MIX_CLIP_COUNT_EN
        chk("reset_clip_count", int'(clip_count), 0);
`endif
    endtask

    task automatic frame_const(input int val, input bit le, input bit re);
        for (int i = 0; i < OPS_PER_FRAME; i++) drive(i == 0, 1, val, 1, le, re);
        idle(3);
        drain();
    endtask

    function automatic int rand_val(input int mode);
        case (mode)
            1:       return int'($urandom_range(3000, 4095));
            2:       return -int'($urandom_range(3000, 4096));
            default: return int'($urandom_range(0, 8191)) - 4096;
        endcase
    endfunction

    // Monitor: every output pulse must match the oldest expected sample and its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sample_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got sample_valid=1, expected 0 (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                chk("sample_l", int'(sample_l), e.l);
                chk("sample_r", int'(sample_r), e.r);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mode;
        do_reset();

        // Directed frames
        frame_const(100, 1, 1);     // 3600 both
        frame_const(4095, 1, 0);    // 147420 clips to 32767, right 0
        frame_const(-4096, 0, 1);   // -147456 clips to -32768, left 0

        // Half carriers, half modulators: only carriers contribute
        for (int i = 0; i < OPS_PER_FRAME; i++)
            drive(i == 0, 1, (i % 2) ? 1000 : 10, (i % 2) == 0, 1, 1);
        idle(3);
        drain();
        chk("frame_error_clean", int'(frame_error), 0);

        // Restart after 20 ops: error, partial frame dropped, next full frame good
        for (int i = 0; i < 20; i++) drive(i == 0, 1, 5, 1, 1, 1);
        frame_const(1, 1, 1);
        chk("frame_error_set", int'(frame_error), 1);

        // Reset mid-frame, then stray ops without a frame strobe
        for (int i = 0; i < 10; i++) drive(i == 0, 1, 50, 1, 1, 1);
        do_reset();
        for (int i = 0; i < 5; i++) drive(0, 1, 7, 1, 1, 1);
        idle(4);
        drain();

        // Randomized frames with gaps, occasionally back-to-back with CLAMP
        for (int f = 0; f < 16; f++) begin
            mode = int'($urandom_range(0, 2));
            drive(1, $urandom_range(0, 1) == 1, rand_val(mode), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            for (int k = 0; k < 400 && m_in_frame; k++)
                drive(0, $urandom_range(0, 3) != 0, rand_val(mode), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            idle(int'($urandom_range(0, 3)));
        end
        idle(3);
        drain();
        chk("frame_error_random", int'(frame_error), int'(m_ferr));
`ifdef OPL3_MIX_CLIP_COUNT_EN
        chk("clip_count", int'(clip_count), m_clips);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
